parity_frame_checker: RTL and testbench
=======================================

PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 Parameter WIDTH, default 4: data word width in bits, legal range >= 1.
REQ-002 Parameter FRAME_LEN, default 4: words per parity frame, legal range >= 2.
REQ-003 Parameter ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-004 Clock  input  1: single clock; all state updates on rising edge.
REQ-005 Reset_b  input  1: asynchronous, active-low reset.
REQ-006 Clear  input  1: synchronous abort and clear, active-high.
REQ-007 Valid  input  1: Data_in is presented this cycle.
REQ-008 Ready  output  1: block accepts a word this cycle; a transfer occurs when Valid & Ready.
REQ-009 Data_in  input  WIDTH: frame data word.
REQ-010 Parity_in  input  1: frame parity bit, sampled only with the last word of a frame.
REQ-011 Busy  output  1: a frame is partially received.
REQ-012 Done  output  1: one-cycle pulse marking a completed frame check.
REQ-013 Error  output  1: result of the most recent completed frame; 1 = parity failure.
REQ-014 Err_count  output  8: count of failed frames.

Function
REQ-015 States SHALL be IDLE, RUN and REPORT; Ready = 1 in IDLE and RUN, 0 in REPORT.
REQ-016 IDLE: a transfer SHALL load acc = XOR-reduce(Data_in), set word count to 1, and move to RUN; with no transfer, state and acc hold.
REQ-017 RUN, non-last word (count < FRAME_LEN-1): a transfer SHALL XOR the reduced word into acc and increment count.
REQ-018 RUN, last word (count = FRAME_LEN-1): a transfer SHALL compute chk = acc ^ XOR-reduce(Data_in) ^ Parity_in ^ ODD, register Error = chk, and move to REPORT.
REQ-019 RUN with Valid = 0 SHALL hold state, acc and count; there is no timeout.
REQ-020 REPORT SHALL assert Done for exactly one cycle, then return to IDLE; Valid is ignored because Ready = 0.
REQ-021 Done SHALL rise in the cycle after the last-word transfer, giving a fixed latency of 1 cycle.
REQ-022 Error SHALL change only when REQ-018 fires and SHALL hold its value until the next frame completes.
REQ-023 Busy SHALL equal 1 exactly when the state is RUN.
REQ-024 Clear SHALL take priority over Valid: next state IDLE, acc = 0, count = 0, Error = 0, Err_count = 0, Done = 0; a partial frame is discarded.
REQ-025 Word count SHALL be $clog2(FRAME_LEN) bits wide and SHALL never exceed FRAME_LEN-1.

Reset
REQ-026 Reset_b low SHALL immediately force state IDLE, acc 0, count 0, Ready 1, Busy 0, Done 0, Error 0 and Err_count 0, independent of Clock.
REQ-027 Reset mid-frame SHALL discard the partial frame; the first transfer after release starts a new frame.

Configuration
REQ-028 With macro PARITY_ERR_CNT_EN defined, Err_count SHALL increment by 1 on each REQ-018 event with chk = 1 and SHALL saturate at 255.
REQ-029 Without PARITY_ERR_CNT_EN, Err_count SHALL be driven constant 0 and no counter logic is built; all other behaviour is unchanged.

Verification
REQ-030 The bench SHALL cover the following directed scenarios; all use WIDTH=4, FRAME_LEN=4, ODD=0 unless stated otherwise.
- Frame 0x1, 0x2, 0x3, 0x0 with Parity_in = 0 -> Done one cycle after the 4th word, Error = 0, Err_count = 0.
- Same frame with Parity_in = 1 -> Error = 1, Err_count = 1 (macro defined) or 0 (macro undefined).
- ODD = 1, same frame with Parity_in = 1 -> Error = 0.
- Valid low for 3 cycles between words 2 and 3 -> Busy held at 1, result identical to the gapless frame, Done lasts exactly 1 cycle.
- Clear asserted with Valid after word 2 -> state IDLE, Error = 0, Err_count = 0, no Done; the next 4 words form a clean frame.
- Reset_b pulsed low asynchronously mid-frame -> outputs at reset values immediately; then 256 failing frames with the macro defined -> Err_count = 255.

Source files
------------

// File: rtl/parity_frame_checker.sv
// Checks a parity bit across a frame of FRAME_LEN words (IDLE -> RUN -> REPORT).
// Optional failed-frame counter is built only when PARITY_ERR_CNT_EN is defined.
module parity_frame_checker #(
   parameter int WIDTH     = 4,
   parameter int FRAME_LEN = 4,
   parameter bit ODD       = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] data_i,
   input  logic             parity_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             error_o,
   output logic [7:0]       err_count_o
);

   localparam int CNT_W = $clog2(FRAME_LEN);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {IDLE, RUN, REPORT} state_e;

   // valid/ready: a word is consumed on a rising edge where valid_i and ready_o
   // are both high; ready_o drops only for the single REPORT cycle.
   state_e           state_q;
   logic             acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic             error_q;

   logic xfer;
   logic word_par;
   logic last_xfer;
   logic error_d;

   assign ready_o   = (state_q != REPORT);
   assign busy_o    = (state_q == RUN);
   assign done_o    = (state_q == REPORT);
   assign error_o   = error_q;

   assign xfer      = valid_i & ready_o;
   assign word_par  = ^data_i;
   assign last_xfer = xfer && (state_q == RUN) && (cnt_q == LAST_CNT);
   assign error_d   = acc_q ^ word_par ^ parity_i ^ ODD;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         acc_q   <= 1'b0;
         cnt_q   <= '0;
         error_q <= 1'b0;
      end else if (clear_i) begin
         state_q <= IDLE;
         acc_q   <= 1'b0;
         cnt_q   <= '0;
         error_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (xfer) begin
                  acc_q   <= word_par;
                  cnt_q   <= CNT_W'(1);
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (last_xfer) begin
                  error_q <= error_d;
                  acc_q   <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= REPORT;
               end else if (xfer) begin
                  acc_q <= acc_q ^ word_par;
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            REPORT: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef PARITY_ERR_CNT_EN
   logic [7:0] err_cnt_q;

   // Saturates at 255 rather than wrapping so a flood of failures stays visible.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_cnt_q <= '0;
      end else if (clear_i) begin
         err_cnt_q <= '0;
      end else if (last_xfer && error_d && (err_cnt_q != 8'hFF)) begin
         err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign err_count_o = err_cnt_q;
`else
   assign err_count_o = 8'd0;
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker: even-parity instance a, odd-parity instance b.
module tb_parity_frame_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0;
   logic       valid_a = 1'b0;
   logic       valid_b = 1'b0;
   logic [3:0] data = 4'h0;
   logic       parity = 1'b0;

   logic       ready_a, busy_a, done_a, error_a;
   logic [7:0] cnt_a;
   logic       ready_b, busy_b, done_b, error_b;
   logic [7:0] cnt_b;

   int tests = 0;
   int failed = 0;

   logic [8:0] exp_a_q[$];
   logic [8:0] exp_b_q[$];
   logic [7:0] exp_cnt_a = 8'd0;
   logic [7:0] exp_cnt_b = 8'd0;

   always #5 clk = ~clk;

   parity_frame_checker #(.WIDTH(4), .FRAME_LEN(4), .ODD(1'b0)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .valid_i(valid_a),
      .ready_o(ready_a), .data_i(data), .parity_i(parity), .busy_o(busy_a),
      .done_o(done_a), .error_o(error_a), .err_count_o(cnt_a)
   );

   parity_frame_checker #(.WIDTH(4), .FRAME_LEN(4), .ODD(1'b1)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .valid_i(valid_b),
      .ready_o(ready_b), .data_i(data), .parity_i(parity), .busy_o(busy_b),
      .done_o(done_b), .error_o(error_b), .err_count_o(cnt_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Next expected saturating error count for an instance.
   function automatic logic [7:0] next_cnt(input logic [7:0] c, input logic err);
`ifdef PARITY_ERR_CNT_EN
      return (err && c != 8'hFF) ? c + 8'd1 : c;
`else
      return (c & 8'h00) | {7'd0, 1'b0 & err};
`endif
   endfunction

   task automatic put_word(input int inst, input logic [3:0] d, input logic p);
      bit accepted = 0;
      data   = d;
      parity = p;
      if (inst == 0) valid_a = 1'b1; else valid_b = 1'b1;
      for (int n = 0; n < 20 && !accepted; n++) begin
         @(negedge clk);
         if ((inst == 0) ? ready_a : ready_b) accepted = 1;
         @(posedge clk);
         #1;
      end
      valid_a = 1'b0;
      valid_b = 1'b0;
      if (!accepted) begin
         tests++;
         failed++;
         $display("FAIL ready_timeout: got ready=0 for 20 cycles expected ready=1");
      end
   endtask

   task automatic send_frame(input int inst, input logic [3:0] w0, input logic [3:0] w1,
                             input logic [3:0] w2, input logic [3:0] w3,
                             input logic p, input logic exp_err);
      put_word(inst, w0, 1'b0);
      put_word(inst, w1, 1'b0);
      put_word(inst, w2, 1'b0);
      if (inst == 0) begin
         exp_cnt_a = next_cnt(exp_cnt_a, exp_err);
         exp_a_q.push_back({exp_err, exp_cnt_a});
      end else begin
         exp_cnt_b = next_cnt(exp_cnt_b, exp_err);
         exp_b_q.push_back({exp_err, exp_cnt_b});
      end
      put_word(inst, w3, p);
   endtask

   // Monitors: every Done pulse must match the oldest expected result and last one cycle.
   logic done_a_prev = 1'b0;
   logic done_b_prev = 1'b0;
   logic [8:0] got;
   logic [8:0] want_a;
   logic [8:0] want_b;

   always @(negedge clk) begin
      if (done_a) begin
         check("a_done_width", {31'd0, done_a_prev}, 32'd0);
         if (exp_a_q.size() == 0) begin
            check("a_unexpected_done", 32'd1, 32'd0);
         end else begin
            want_a = exp_a_q.pop_front();
            check("a_result", {23'd0, error_a, cnt_a}, {23'd0, want_a});
         end
      end
      done_a_prev = done_a;
   end

   always @(negedge clk) begin
      if (done_b) begin
         check("b_done_width", {31'd0, done_b_prev}, 32'd0);
         if (exp_b_q.size() == 0) begin
            check("b_unexpected_done", 32'd1, 32'd0);
         end else begin
            want_b = exp_b_q.pop_front();
            check("b_result", {23'd0, error_b, cnt_b}, {23'd0, want_b});
         end
      end
      done_b_prev = done_b;
   end

   initial begin
      // reset state
      #2;
      check("rst_ready", {31'd0, ready_a}, 32'd1);
      check("rst_busy",  {31'd0, busy_a},  32'd0);
      check("rst_done",  {31'd0, done_a},  32'd0);
      check("rst_error", {31'd0, error_a}, 32'd0);
      check("rst_cnt",   {24'd0, cnt_a},   32'd0);
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1,2,3,0: reduced parities 1,1,0,0 -> even; parity 0 passes, parity 1 fails
      send_frame(0, 4'h1, 4'h2, 4'h3, 4'h0, 1'b0, 1'b0);
      check("report_ready", {31'd0, ready_a}, 32'd0);
      send_frame(0, 4'h1, 4'h2, 4'h3, 4'h0, 1'b1, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      check("error_hold", {31'd0, error_a}, 32'd1);

      // odd parity: same data with parity 1 passes, with parity 0 fails
      send_frame(1, 4'h1, 4'h2, 4'h3, 4'h0, 1'b1, 1'b0);
      send_frame(1, 4'h1, 4'h2, 4'h3, 4'h0, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #1;

      // gap of 3 idle cycles mid-frame
      put_word(0, 4'h1, 1'b0);
      put_word(0, 4'h2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("gap_busy", {31'd0, busy_a}, 32'd1);
         @(posedge clk);
         #1;
      end
      exp_cnt_a = next_cnt(exp_cnt_a, 1'b0);
      exp_a_q.push_back({1'b0, exp_cnt_a});
      put_word(0, 4'h3, 1'b0);
      put_word(0, 4'h0, 1'b0);
      repeat (2) @(posedge clk);
      #1;

      // make Error=1 first so the clear is observable
      send_frame(0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      send_frame(0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      put_word(0, 4'h1, 1'b0);
      put_word(0, 4'h0, 1'b0);
      clear   = 1'b1;
      valid_a = 1'b1;
      data    = 4'h5;
      @(posedge clk);
      #1;
      clear   = 1'b0;
      valid_a = 1'b0;
      exp_cnt_a = 8'd0;
      check("clr_busy",  {31'd0, busy_a},  32'd0);
      check("clr_ready", {31'd0, ready_a}, 32'd1);
      check("clr_error", {31'd0, error_a}, 32'd0);
      check("clr_cnt",   {24'd0, cnt_a},   32'd0);
      // 7,1,0,8 reduce to 1,1,0,1 -> parity 1 is correct
      send_frame(0, 4'h7, 4'h1, 4'h0, 4'h8, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #1;

      // failing frame, then asynchronous reset mid-frame
      send_frame(0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      put_word(0, 4'h1, 1'b0);
      put_word(0, 4'h2, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_ready", {31'd0, ready_a}, 32'd1);
      check("arst_busy",  {31'd0, busy_a},  32'd0);
      check("arst_done",  {31'd0, done_a},  32'd0);
      check("arst_error", {31'd0, error_a}, 32'd0);
      check("arst_cnt",   {24'd0, cnt_a},   32'd0);
      exp_cnt_a = 8'd0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 256 failing frames: counter saturates at 255
      for (int f = 0; f < 256; f++) begin
         send_frame(0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
      end
      repeat (3) @(posedge clk);
      #1;
`ifdef PARITY_ERR_CNT_EN
      check("sat_cnt", {24'd0, cnt_a}, 32'd255);
`else
      check("sat_cnt", {24'd0, cnt_a}, 32'd0);
`endif
      check("sat_error", {31'd0, error_a}, 32'd1);

      check("a_queue_empty", exp_a_q.size(), 32'd0);
      check("b_queue_empty", exp_b_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
